// File: rtl/cnt_snapshot_logger.sv
// cnt_snapshot_logger: logs din snapshots into consecutive RAM write addresses on each sample strobe
module cnt_snapshot_logger #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              Reset_N,
  input  logic              EN,
  input  logic              start,
  input  logic              stop,
  input  logic              sample,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   level
);
  typedef enum logic [1:0] {IDLE, LOGGING, FULL} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LDEP = (ADDR_W + 1)'(DEPTH);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                acc;
  logic                pend_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic [DATA_W-1:0]   pend_data_q;
  logic                wren_q, busy_q, full_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    level_d = level_q;
    acc     = 1'b0;
    if (EN) begin
      if (stop) begin
        state_d = IDLE;
      end else if (start) begin
        state_d = LOGGING;
        ptr_d   = '0;
        level_d = '0;
      end else if (sample && state_q == LOGGING) begin
        acc     = 1'b1;
        ptr_d   = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        level_d = (level_q == LDEP) ? level_q : level_q + 1'b1;
        state_d = (WRAP == 0 && level_q + 1'b1 == LDEP) ? FULL : LOGGING;
      end
    end
  end
  // Accepted samples sit one cycle in the pend stage; reset there cancels the write
  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      level_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      level_q     <= level_d;
      pend_q      <= acc;
      pend_addr_q <= ptr_q;
      pend_data_q <= din;
      wren_q      <= pend_q;
      addr_q      <= pend_q ? pend_addr_q : addr_q;
      data_q      <= pend_q ? pend_data_q : data_q;
      busy_q      <= state_d == LOGGING;
      full_q      <= level_d == LDEP;
    end
  end
  assign wraddress = addr_q;
  assign data      = data_q;
  assign wren      = wren_q;
  assign busy      = busy_q;
  assign full      = full_q;
  assign level     = level_q;
endmodule
